// File: rtl/paillier_decrypt_if.sv
// rtl/paillier_decrypt_if.sv - ModMult request/response channel between the decryptor and the modular multiplier
interface paillier_decrypt_if #(
    parameter int DATA_WIDTH = 256
);
    logic                      mm_din_valid;
    logic                      mm_din_ready;
    logic [2*DATA_WIDTH-1:0]   mm_a;
    logic [2*DATA_WIDTH-1:0]   mm_b;
    logic [2*DATA_WIDTH-1:0]   mm_mod;
    logic                      mm_dout_valid;
    logic                      mm_dout_ready;
    logic [2*DATA_WIDTH-1:0]   mm_res;

    modport master (
        output mm_din_valid, mm_a, mm_b, mm_mod, mm_dout_ready,
        input  mm_din_ready, mm_dout_valid, mm_res
    );

    modport slave (
        input  mm_din_valid, mm_a, mm_b, mm_mod, mm_dout_ready,
        output mm_din_ready, mm_dout_valid, mm_res
    );
endinterface

// File: rtl/paillier_decrypt.sv
// rtl/paillier_decrypt.sv - Paillier batch decryptor: m = L(c^lambda mod n^2) * u mod n per RAM ciphertext
module paillier_decrypt #(
    parameter int DATA_WIDTH    = 256,
    parameter int ADDRESS_WIDTH = 64,
    parameter int FILE_SIZE     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       done,
    output logic                       err,
    input  logic [DATA_WIDTH-1:0]      n_in,
    input  logic [DATA_WIDTH-1:0]      lambda_in,
    input  logic [DATA_WIDTH-1:0]      u_in,
    output logic [ADDRESS_WIDTH-1:0]   addr_rd_out,
    input  logic [2*DATA_WIDTH-1:0]    mem_rd_data,
    output logic [ADDRESS_WIDTH-1:0]   addr_wr_out,
    output logic [DATA_WIDTH-1:0]      mem_wr_data,
    output logic                       mem_wr_en,
    paillier_decrypt_if.master         mm
);
    localparam int DW  = DATA_WIDTH;
    localparam int W2  = 2 * DATA_WIDTH;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int IW  = $clog2(DW);
    localparam int DCW = $clog2(W2);
    localparam int CW  = $clog2(FILE_SIZE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_READ, S_LOAD, S_SQ, S_MUL, S_DIV, S_MULU, S_WRITE, S_DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   n_q, lambda_q, u_q, wr_data_q, rem_q;
    logic [W2-1:0]   n2_q, c_q, acc_q, div_q, a_q, b_q, mod_q;
    logic [IW-1:0]   bit_q;
    logic [DCW-1:0]  div_cnt_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_rd_q, addr_wr_q;
    logic            done_q, err_q, wr_en_q, din_valid_q, dout_ready_q;

    logic [DW:0]     rem_sh;
    logic            div_ge;
    logic [DW-1:0]   rem_d;
    logic [W2-1:0]   div_d, op_a, op_b, op_mod;
    logic            mm_state, mm_issue, mm_got;

    // One restoring-division step: shift in the next dividend bit, subtract n when it fits.
    always_comb begin
        rem_sh = {rem_q, div_q[W2-1]};
        div_ge = rem_sh >= {1'b0, n_q};
        rem_d  = div_ge ? DW'(rem_sh - {1'b0, n_q}) : rem_sh[DW-1:0];
        div_d  = {div_q[W2-2:0], div_ge};
    end

    always_comb begin
        op_a   = acc_q;
        op_b   = acc_q;
        op_mod = n2_q;
        if (state_q == S_MUL) begin
            op_b = c_q;
        end else if (state_q == S_MULU) begin
            op_a   = {{DW{1'b0}}, div_q[DW-1:0]};
            op_b   = {{DW{1'b0}}, u_q};
            op_mod = {{DW{1'b0}}, n_q};
        end
        mm_state = (state_q == S_SQ) || (state_q == S_MUL) || (state_q == S_MULU);
        mm_issue = mm_state && !din_valid_q && !dout_ready_q;
        mm_got   = dout_ready_q && mm.mm_dout_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            lambda_q     <= '0;
            u_q          <= '0;
            wr_data_q    <= '0;
            rem_q        <= '0;
            n2_q         <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            div_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mod_q        <= '0;
            bit_q        <= '0;
            div_cnt_q    <= '0;
            cnt_q        <= '0;
            addr_rd_q    <= '0;
            addr_wr_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            din_valid_q  <= 1'b0;
            dout_ready_q <= 1'b0;
        end else begin
            // Request phase holds operands until transfer, then the response phase waits for the result.
            if (mm_issue) begin
                din_valid_q <= 1'b1;
                a_q         <= op_a;
                b_q         <= op_b;
                mod_q       <= op_mod;
            end
            if (din_valid_q && mm.mm_din_ready) begin
                din_valid_q  <= 1'b0;
                dout_ready_q <= 1'b1;
            end
            if (mm_got) begin
                dout_ready_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q       <= n_in;
                        lambda_q  <= lambda_in;
                        u_q       <= u_in;
                        n2_q      <= W2'(n_in) * W2'(n_in);
                        cnt_q     <= '0;
                        addr_rd_q <= '0;
                        addr_wr_q <= '0;
                        err_q     <= 1'b0;
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (n_q < DW'(2)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_READ: state_q <= S_LOAD;
                S_LOAD: begin
                    c_q     <= mem_rd_data;
                    acc_q   <= W2'(1);
                    bit_q   <= IW'(DW - 1);
                    state_q <= S_SQ;
                end
                S_SQ, S_MUL: begin
                    if (mm_got) begin
                        acc_q <= mm.mm_res;
                        if (state_q == S_SQ && lambda_q[bit_q]) begin
                            state_q <= S_MUL;
                        end else if (bit_q == '0) begin
                            div_q     <= mm.mm_res - W2'(1);
                            rem_q     <= '0;
                            div_cnt_q <= '0;
                            state_q   <= S_DIV;
                        end else begin
                            bit_q   <= bit_q - IW'(1);
                            state_q <= S_SQ;
                        end
                    end
                end
                S_DIV: begin
                    rem_q     <= rem_d;
                    div_q     <= div_d;
                    div_cnt_q <= div_cnt_q + DCW'(1);
                    if (div_cnt_q == DCW'(W2 - 1)) begin
                        state_q <= S_MULU;
                    end
                end
                S_MULU: begin
                    if (mm_got) begin
                        wr_data_q <= mm.mm_res[DW-1:0];
                        wr_en_q   <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(FILE_SIZE)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_rd_q <= addr_rd_q + AW'(1);
                        addr_wr_q <= addr_wr_q + AW'(1);
                        state_q   <= S_READ;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done             = done_q;
    assign err              = err_q;
    assign addr_rd_out      = addr_rd_q;
    assign addr_wr_out      = addr_wr_q;
    assign mem_wr_data      = wr_data_q;
    assign mem_wr_en        = wr_en_q;
    assign mm.mm_din_valid  = din_valid_q;
    assign mm.mm_a          = a_q;
    assign mm.mm_b          = b_q;
    assign mm.mm_mod        = mod_q;
    assign mm.mm_dout_ready = dout_ready_q;
endmodule

// File: tb/tb_paillier_decrypt.sv
// tb/tb_paillier_decrypt.sv - directed bench for paillier_decrypt with a stalling ModMult model
module tb_paillier_decrypt;
    localparam int DW = 16;
    localparam int W2 = 32;
    localparam int AW = 64;
    localparam int FS = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           done, err;
    logic [DW-1:0]  n_in = 16'd77, lambda_in = 16'd60, u_in = 16'd9;
    logic [AW-1:0]  addr_rd_out, addr_wr_out;
    logic [W2-1:0]  mem_rd_data = '0;
    logic [DW-1:0]  mem_wr_data;
    logic           mem_wr_en;

    paillier_decrypt_if #(.DATA_WIDTH(DW)) mm_bus();

    paillier_decrypt #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FILE_SIZE(FS)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .err(err),
        .n_in(n_in), .lambda_in(lambda_in), .u_in(u_in),
        .addr_rd_out(addr_rd_out), .mem_rd_data(mem_rd_data),
        .addr_wr_out(addr_wr_out), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mm(mm_bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0, done_cnt = 0, din_seen = 0, wr_at_done = 0;
    int wb, db, vb, k;
    logic [AW-1:0] wr_addr_log [64];
    logic [DW-1:0] wr_data_log [64];
    logic [W2-1:0] ram [3];
    bit            stall = 1'b0;

    always @(posedge clk) begin
        if (addr_rd_out < 64'd3) mem_rd_data <= ram[addr_rd_out[1:0]];
        else                     mem_rd_data <= '0;
    end

    // ModMult reference: random accept stalls, 1-5 cycle result latency, flushed by rst.
    logic          m_busy;
    int            m_lat;
    logic [W2-1:0] m_val;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_lat  <= 0;
            m_val  <= '0;
            mm_bus.mm_din_ready  <= 1'b0;
            mm_bus.mm_dout_valid <= 1'b0;
            mm_bus.mm_res        <= '0;
        end else if (!m_busy) begin
            if (mm_bus.mm_din_valid && mm_bus.mm_din_ready) begin
                m_busy <= 1'b1;
                m_lat  <= int'($urandom_range(1, 5));
                m_val  <= W2'((64'(mm_bus.mm_a) * 64'(mm_bus.mm_b)) % 64'(mm_bus.mm_mod));
                mm_bus.mm_din_ready <= 1'b0;
            end else begin
                mm_bus.mm_din_ready <= !stall && ($urandom_range(0, 1) == 1);
            end
        end else begin
            if (mm_bus.mm_dout_valid) begin
                if (mm_bus.mm_dout_ready) begin
                    mm_bus.mm_dout_valid <= 1'b0;
                    m_busy <= 1'b0;
                end
            end else if (m_lat <= 1) begin
                mm_bus.mm_dout_valid <= 1'b1;
                mm_bus.mm_res        <= m_val;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1 && wr_cnt < 64) begin
            wr_addr_log[wr_cnt] = addr_wr_out;
            wr_data_log[wr_cnt] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (done === 1'b1) begin
            done_cnt   = done_cnt + 1;
            wr_at_done = wr_cnt;
        end
        if (mm_bus.mm_din_valid === 1'b1) din_seen = din_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        wb = wr_cnt;
        db = done_cnt;
        vb = din_seen;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_batch(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                               input logic [DW-1:0] e2);
        logic [DW-1:0] exp_d [3];
        exp_d[0] = e0;
        exp_d[1] = e1;
        exp_d[2] = e2;
        check({tag, "_wr_count"}, 64'(wr_cnt - wb), 64'd3);
        check({tag, "_done_count"}, 64'(done_cnt - db), 64'd1);
        check({tag, "_done_after_writes"}, 64'(wr_at_done - wb), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_log[wb + i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_data_log[wb + i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        ram[0] = 32'd3235; ram[1] = 32'd1; ram[2] = 32'd78;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_din_valid", 64'(mm_bus.mm_din_valid), 64'd0);
        check("rst_dout_ready", 64'(mm_bus.mm_dout_ready), 64'd0);
        check("rst_addr_rd", addr_rd_out, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: 3235 decrypts to 42 at address 0
        mark();
        pulse_start();
        wait_done("t1_done", 5000, k);
        check_batch("t1", 16'd42, 16'd0, 16'd1);

        // T2
        ram[0] = 32'd1; ram[1] = 32'd78; ram[2] = 32'd3235;
        mark();
        pulse_start();
        wait_done("t2_done", 5000, k);
        check_batch("t2", 16'd0, 16'd1, 16'd42);
        check("t2_addr_rd_hold", addr_rd_out, 64'd2);

        // T3: n<2 aborts with no memory or ModMult traffic
        n_in = 16'd1;
        mark();
        pulse_start();
        wait_done("t3_done", 10, k);
        check("t3_latency_ok", 64'(k <= 3), 64'd1);
        check("t3_err", 64'(err), 64'd1);
        check("t3_no_write", 64'(wr_cnt - wb), 64'd0);
        check("t3_no_mm", 64'(din_seen - vb), 64'd0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", 64'(err), 64'd1);
        n_in = 16'd77;

        // T4: first request (1*1 mod 5929) must be held through a 20-cycle stall
        stall = 1'b1;
        repeat (3) @(negedge clk);
        mark();
        pulse_start();
        check("t4_err_cleared", 64'(err), 64'd0);
        k = 0;
        while (mm_bus.mm_din_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t4_valid_seen", 64'(mm_bus.mm_din_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(mm_bus.mm_din_valid), 64'd1);
            check("t4_hold_a", 64'(mm_bus.mm_a), 64'd1);
            check("t4_hold_b", 64'(mm_bus.mm_b), 64'd1);
            check("t4_hold_mod", 64'(mm_bus.mm_mod), 64'd5929);
        end
        stall = 1'b0;
        wait_done("t4_done", 5000, k);
        check_batch("t4", 16'd0, 16'd1, 16'd42);

        // T5: reset while waiting for a squaring result of ciphertext 1
        mark();
        pulse_start();
        k = 0;
        while (!((wr_cnt - wb) >= 1 && mm_bus.mm_dout_ready === 1'b1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_sq_wait", 64'(mm_bus.mm_dout_ready), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_ctrl", {59'd0, done, err, mem_wr_en, mm_bus.mm_din_valid, mm_bus.mm_dout_ready}, 64'd0);
        check("t5_rst_addr_rd", addr_rd_out, 64'd0);
        check("t5_rst_addr_wr", addr_wr_out, 64'd0);
        check("t5_rst_wr_data", 64'(mem_wr_data), 64'd0);
        check("t5_rst_mm_ops", {mm_bus.mm_a, mm_bus.mm_b} | 64'(mm_bus.mm_mod), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mark();
        pulse_start();
        wait_done("t5_done", 5000, k);
        check_batch("t5", 16'd0, 16'd1, 16'd42);

        // T6: start and key changes while busy are ignored
        mark();
        pulse_start();
        repeat (40) @(negedge clk);
        start = 1'b1;
        n_in = 16'd55; lambda_in = 16'd7; u_in = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6_done", 5000, k);
        check_batch("t6", 16'd0, 16'd1, 16'd42);
        vb = din_seen;
        repeat (10) @(negedge clk);
        check("t6_no_restart", 64'(din_seen - vb), 64'd0);
        n_in = 16'd77; u_in = 16'd9;

        // lambda = 0 keeps acc at 1, so every plaintext is 0
        lambda_in = 16'd0;
        ram[0] = 32'd3235; ram[1] = 32'd3235; ram[2] = 32'd3235;
        mark();
        pulse_start();
        wait_done("l0_done", 5000, k);
        check_batch("l0", 16'd0, 16'd0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
